mwb_stage: RTL
==============

// Module: mwb_stage
// PURPOSE
//  Consumer end of the EXE->MWB pipeline register: memory/writeback stage of the 3-stage RISC-V core.
//  Issues DMEM load/store requests on a valid/ready bus and waits for load responses.
//  Sign/zero-extends load data, selects the writeback source and writes the register file.
//  Stalls upstream while a memory access is outstanding.
// PARAMETERS
//  XLEN        32  datapath width; only 32 is supported
//  MEM_ADDR_W  32  width of mem_addr
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset, synchronous, active-high
//  in_valid       in   1     EXE->MWB register holds a real instruction
//  instruction_in in   32    instruction; rd=[11:7], store width=funct3[14:12]
//  alu_result_in  in   32    ALU result / effective address
//  imme_result_in in   32    immediate (LUI)
//  pc_in          in   32    PC of the instruction
//  rs2_data_in    in   32    store data
//  reg_we_in      in   1     instruction writes rd
//  dmem_sel_in    in   2     00 none, 01 load, 10 store, 11 reserved (treated as none)
//  load_sel_in    in   3     000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  wb_sel_in      in   2     00 ALU, 01 load data, 10 PC+4, 11 IMME
//  stall_o        out  1     upstream must hold its register and not advance
//  mem_req_valid  out  1     DMEM request valid
//  mem_req_ready  in   1     DMEM accepts the request
//  mem_addr       out  MEM_ADDR_W  word-aligned address {alu[31:2],2'b00}
//  mem_we         out  1     1=store, 0=load
//  mem_wstrb      out  4     store byte enables
//  mem_wdata      out  32    store data, lane-replicated
//  mem_rsp_valid  in   1     load data valid
//  mem_rsp_rdata  in   32    load data word
//  rf_we          out  1     register-file write enable
//  rf_waddr       out  5     rd
//  rf_wdata       out  32    writeback data
//  misalign_o     out  1     misaligned-access pulse (MWB_MISALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - Accept: in_valid & ~stall_o. stall_o = (state != IDLE); combinational from the state only.
//  - FSM states: IDLE, REQ, WAIT, WB.
//    - IDLE, accept of a non-memory op: no state change; rf_we=reg_we_in & (rd!=0) at T+1, registered.
//      Throughput is 1 per cycle.
//    - IDLE, accept of a load or store -> REQ. Request fields are latched at the accept edge.
//    - REQ: mem_req_valid=1; fields held stable until mem_req_ready.
//      - Store + ready -> IDLE. No register write.
//      - Load + ready -> WAIT.
//    - WAIT: on mem_rsp_valid, capture the aligned/extended data -> WB. A response in REQ is ignored.
//    - WB: rf_we=1 (when rd!=0 and reg_we), rf_wdata=load data; -> IDLE.
//      Load-to-writeback latency is at least 3 cycles after accept.
//  - Load extract: byte offset = alu[1:0].
//    - LB/LBU: byte at offset, sign/zero-extended.
//    - LH/LHU: half at alu[1].
//    - LW: whole word.
//  - Store:
//    - SB: wstrb=0001<<off, wdata={4{rs2[7:0]}}.
//    - SH: wstrb=0011<<(2*alu[1]), wdata={2{rs2[15:0]}}.
//    - SW: wstrb=1111, wdata=rs2.
//  - Writeback mux: 00 ALU, 01 load, 10 pc+4 (mod 2^32), 11 IMME.
//  - rf_we is a one-cycle pulse. rd==0 never writes.
//  - Reset: state=IDLE; all outputs 0, including mem_req_valid, rf_we, rf_waddr, rf_wdata and misalign_o.
//  - Reset mid-operation abandons the access. mem_req_valid is 0 in the cycle after the reset edge.
//  - in_valid=0 in IDLE: no effect. Inputs are ignored while stall_o=1.
// CONFIGURATION
//  - MWB_MISALIGN_CHECK_EN defined:
//    - Misaligned access: LH/LHU/SH with alu[0]=1, or LW/SW with alu[1:0]!=0.
//    - No request is issued, no rf write, state stays IDLE.
//    - misalign_o pulses 1 cycle at T+1.
//  - Undefined: no check; misalign_o tied 0. Offsets apply as above; lanes past the word boundary are dropped.
// STRUCTURE
//  - mwb_pkg: DMEM_SEL_*, LOAD_SEL_*, WB_SEL_*, store funct3 codes and the state enum.
//  - Sub-module mwb_load_align: combinational word -> extended value from load_sel and offset.
// TESTING
//  1. ALU op, rd=5, alu=0x1234, wb_sel=00 -> rf_we=1, waddr=5, wdata=0x1234 at T+1; stall_o stays 0.
//  2. LB, alu=0x103, rdata=0x80FFFFFF, ready immediate, rsp 2 cycles later -> wdata=0xFFFFFF80.
//     stall_o high from T+1 until the WB cycle.
//  3. SH, alu=0x202, rs2=0xABCD -> addr=0x200, wstrb=1100, wdata=0xABCDABCD.
//     With ready low 3 cycles, fields are held stable and there is no rf write.
//  4. JAL-type op, wb_sel=10, pc=0xFFFFFFFC -> wdata=0x00000000. Same op with rd=0 -> rf_we stays 0.
//  5. rst asserted in WAIT -> outputs 0 next cycle; a late mem_rsp_valid causes no rf write.
//  6. MWB_MISALIGN_CHECK_EN: LW with alu=0x6 -> misalign_o pulse; mem_req_valid and rf_we stay 0.

Source files
------------

// File: rtl/mwb_pkg.sv
// Shared encodings, FSM states and store/misalign helpers
// for the memory/writeback stage.
package mwb_pkg;

  localparam logic [1:0] DMEM_SEL_NONE  = 2'b00;
  localparam logic [1:0] DMEM_SEL_LOAD  = 2'b01;
  localparam logic [1:0] DMEM_SEL_STORE = 2'b10;
  localparam logic [1:0] DMEM_SEL_RSVD  = 2'b11;

  localparam logic [2:0] LOAD_SEL_LB  = 3'b000;
  localparam logic [2:0] LOAD_SEL_LH  = 3'b001;
  localparam logic [2:0] LOAD_SEL_LW  = 3'b010;
  localparam logic [2:0] LOAD_SEL_LBU = 3'b100;
  localparam logic [2:0] LOAD_SEL_LHU = 3'b101;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [2:0] ST_F3_SB = 3'b000;
  localparam logic [2:0] ST_F3_SH = 3'b001;
  localparam logic [2:0] ST_F3_SW = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_WB   = 2'b11
  } mwb_state_e;

  // Unknown store widths behave as SW.
  function automatic logic [3:0] store_strb(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] s;
    case (f3)
      ST_F3_SB: s = 4'b0001 << off;
      ST_F3_SH: s = 4'b0011 << {off[1], 1'b0};
      default:  s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [2:0]  f3,
    input logic [31:0] rs2
  );
    logic [31:0] d;
    case (f3)
      ST_F3_SB: d = {4{rs2[7:0]}};
      ST_F3_SH: d = {2{rs2[15:0]}};
      default:  d = rs2;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(
    input logic       is_load,
    input logic [2:0] load_sel,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    if (is_load) begin
      case (load_sel)
        LOAD_SEL_LB, LOAD_SEL_LBU: m = 1'b0;
        LOAD_SEL_LH, LOAD_SEL_LHU: m = off[0];
        default:                   m = |off;
      endcase
    end else begin
      case (f3)
        ST_F3_SB: m = 1'b0;
        ST_F3_SH: m = off[0];
        default:  m = |off;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/mwb_load_align.sv
// Load data aligner: picks byte/half/word from the response
// word by offset and sign/zero-extends it. Purely combinational.
module mwb_load_align
  import mwb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  load_sel,
  input  logic [1:0]  off,
  output logic [31:0] value
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = word >> {off, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    value = word;
    case (load_sel)
      LOAD_SEL_LB:  value = {{24{byte_v[7]}}, byte_v};
      LOAD_SEL_LBU: value = {24'h0, byte_v};
      LOAD_SEL_LH:  value = {{16{half_v[15]}}, half_v};
      LOAD_SEL_LHU: value = {16'h0, half_v};
      default:      value = word;
    endcase
  end

endmodule

// File: rtl/mwb_stage.sv
// Memory/writeback stage: issues DMEM requests, aligns load data,
// writes the register file and stalls upstream during accesses.
// Ports: pipeline inputs (*_in), stall_o, DMEM req/rsp bus,
// rf_we/rf_waddr/rf_wdata, misalign_o.
// Optional: define MWB_MISALIGN_CHECK_EN to trap misaligned
// accesses (pulse misalign_o, issue nothing).
module mwb_stage
  import mwb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           instruction_in,
  input  logic [XLEN-1:0]       alu_result_in,
  input  logic [XLEN-1:0]       imme_result_in,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic                  reg_we_in,
  input  logic [1:0]            dmem_sel_in,
  input  logic [2:0]            load_sel_in,
  input  logic [1:0]            wb_sel_in,
  output logic                  stall_o,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_rdata,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  misalign_o
);

  mwb_state_e state;
  mwb_state_e state_nx;

  logic [4:0]  rd;
  logic [2:0]  st_f3;
  logic [1:0]  off;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        accept;
  logic        misal;
  logic        go_mem;
  logic [31:0] wb_val;
  logic [31:0] ld_val;

  logic [MEM_ADDR_W-1:0] addr_q;
  logic        we_q;
  logic [3:0]  strb_q;
  logic [31:0] wdata_q;
  logic [2:0]  ld_sel_q;
  logic [1:0]  ld_off_q;
  logic [4:0]  rd_q;
  logic        rwe_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  logic unused_instr;
  assign unused_instr = ^{instruction_in[31:15],
                          instruction_in[6:0]};

  assign rd       = instruction_in[11:7];
  assign st_f3    = instruction_in[14:12];
  assign off      = alu_result_in[1:0];
  assign is_load  = (dmem_sel_in == DMEM_SEL_LOAD);
  assign is_store = (dmem_sel_in == DMEM_SEL_STORE);
  assign is_mem   = is_load | is_store;
  assign accept   = in_valid & ~stall_o;

`ifdef MWB_MISALIGN_CHECK_EN
  logic misal_q;

  assign misal = is_mem &
                 misaligned(is_load, load_sel_in, st_f3, off);

  always_ff @(posedge clk) begin
    if (rst) misal_q <= 1'b0;
    else     misal_q <= accept & misal;
  end

  assign misalign_o = misal_q;
`else
  assign misal      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign go_mem = accept & is_mem & ~misal;

  // Non-memory writeback; wb_sel LOAD without a load has no data.
  always_comb begin
    wb_val = '0;
    unique case (wb_sel_in)
      WB_SEL_ALU:  wb_val = alu_result_in;
      WB_SEL_LOAD: wb_val = '0;
      WB_SEL_PC4:  wb_val = pc_in + XLEN'(4);
      WB_SEL_IMM:  wb_val = imme_result_in;
    endcase
  end

  mwb_load_align u_align (
    .word     (mem_rsp_rdata),
    .load_sel (ld_sel_q),
    .off      (ld_off_q),
    .value    (ld_val)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (go_mem) state_nx = ST_REQ;
      ST_REQ: begin
        if (mem_req_ready)
          state_nx = we_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: if (mem_rsp_valid) state_nx = ST_WB;
      ST_WB:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o       = (state != ST_IDLE);
    mem_req_valid = (state == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      strb_q     <= '0;
      wdata_q    <= '0;
      ld_sel_q   <= '0;
      ld_off_q   <= '0;
      rd_q       <= '0;
      rwe_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      if (go_mem) begin
        addr_q   <= MEM_ADDR_W'({alu_result_in[31:2], 2'b00});
        we_q     <= is_store;
        strb_q   <= is_store ? store_strb(st_f3, off) : 4'b0000;
        wdata_q  <= is_store ?
                    store_data(st_f3, rs2_data_in) : 32'h0;
        ld_sel_q <= load_sel_in;
        ld_off_q <= off;
        rd_q     <= rd;
        rwe_q    <= reg_we_in;
      end
      if (accept & ~is_mem) begin
        rf_we_q    <= reg_we_in & (rd != 5'd0);
        rf_waddr_q <= rd;
        rf_wdata_q <= wb_val;
      end
      // Capture on the response so the write shows in the WB cycle.
      if (state == ST_WAIT && mem_rsp_valid) begin
        rf_we_q    <= rwe_q & (rd_q != 5'd0);
        rf_waddr_q <= rd_q;
        rf_wdata_q <= ld_val;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wstrb = strb_q;
  assign mem_wdata = wdata_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

endmodule
